// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types, default sizes and helpers for the
//                scoreboarded register file.
//                  rf_state_e : clear-sequencer state encoding
//                  RF_*       : default data width / register count / ports
//                  rf_aw()    : index width for a register count
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;

    // A single-entry file still needs a one-bit index to keep widths legal.
    function automatic int rf_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Issue / writeback / read bundle of the register file.
//                  ready    : file has finished clearing (slave -> master)
//                  wen/wsel/wdata       : writeback port
//                  rsel/rdata/rbusy     : NRD packed read ports
//                  issue_en/issue_rd    : mark destination busy
//                master = decode/issue + writeback side, slave = register file
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
) ();

    localparam int c_AW = rf_aw(NREGS);

    logic                  ready;
    logic                  wen;
    logic [c_AW-1:0]       wsel;
    logic [XLEN-1:0]       wdata;
    logic [NRD*c_AW-1:0]   rsel;
    logic [NRD*XLEN-1:0]   rdata;
    logic [NRD-1:0]        rbusy;
    logic                  issue_en;
    logic [c_AW-1:0]       issue_rd;

    modport master (
        input  ready, rdata, rbusy,
        output wen, wsel, wdata, rsel, issue_en, issue_rd
    );

    modport slave (
        output ready, rdata, rbusy,
        input  wen, wsel, wdata, rsel, issue_en, issue_rd
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits for the register file.
//                  clk, rst   : clock, synchronous active-high reset
//                  i_set_en/i_set_idx : issue marks a register busy
//                  i_clr_en/i_clr_idx : writeback clears a register
//                  i_rsel     : read indices, one per port
//                  i_rvalid   : port index is a real, non-zero register in RUN
//                  i_rbyp     : port is being forwarded this cycle
//                  o_rbusy    : port's register still has a producer in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = 5
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_set_en,
    input  wire logic [AW-1:0]            i_set_idx,
    input  wire logic                     i_clr_en,
    input  wire logic [AW-1:0]            i_clr_idx,
    input  wire logic [NRD-1:0][AW-1:0]   i_rsel,
    input  wire logic [NRD-1:0]           i_rvalid,
    input  wire logic [NRD-1:0]           i_rbyp,
    output logic      [NRD-1:0]           o_rbusy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Set is applied after clear: a register re-issued on the same edge it
    // is written back belongs to the newer producer and must stay busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // i_rvalid gates the lookup so out-of-range indices never reach r_busy.
    always_comb begin
        o_rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            o_rbusy[i] = i_rvalid[i] && !i_rbyp[i] && r_busy[i_rsel[i]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Parametrised integer register file with busy scoreboard,
//                optional zero register, optional write-to-read bypass and a
//                post-reset clear sequencer (array itself has no reset).
//                  clk, rst : clock, synchronous active-high reset
//                  bus      : regfile_sb_if.slave (ready, write, read, issue)
//                The interface instance must use the same XLEN/NREGS/NRD.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = RF_NRD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    regfile_sb_if.slave  bus
);

    localparam int              c_AW   = rf_aw(NREGS);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(NREGS - 1);

    rf_state_e                     r_state;
    rf_state_e                     w_state_nxt;
    logic [c_AW-1:0]               r_clr_idx;
    logic [c_AW-1:0]               w_clr_idx_nxt;
    logic [XLEN-1:0]               r_mem [NREGS];

    logic                          w_run;
    logic                          w_wr_ok;
    logic                          w_set_ok;
    logic                          w_mem_we;
    logic [c_AW-1:0]               w_mem_addr;
    logic [XLEN-1:0]               w_mem_din;
    logic [NRD-1:0][c_AW-1:0]      w_rsel;
    logic [NRD-1:0]                w_rvalid;
    logic [NRD-1:0]                w_rbyp;
    logic [NRD-1:0][XLEN-1:0]      w_rdata;

    // True for indices that name a real, writable register.
    function automatic logic idx_ok(input logic [c_AW-1:0] idx);
        return (int'(idx) < NREGS) && !(ZERO_REG && (idx == '0));
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == c_LAST) begin
                    w_state_nxt   = RUN;
                    w_clr_idx_nxt = '0;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
    end

    assign w_run     = (r_state == RUN);
    assign bus.ready = w_run;

    // ---------------------------------------------------------------- array
    assign w_wr_ok  = w_run && bus.wen && idx_ok(bus.wsel);
    assign w_set_ok = w_run && bus.issue_en && idx_ok(bus.issue_rd);

    // The clear sequencer and writeback share the single write port; the
    // FSM state decides which one owns it.
    assign w_mem_we   = !rst && (!w_run || w_wr_ok);
    assign w_mem_addr = w_run ? bus.wsel  : r_clr_idx;
    assign w_mem_din  = w_run ? bus.wdata : '0;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // ---------------------------------------------------------------- reads
    assign w_rsel = bus.rsel;

    // Outputs are forced to zero during CLEAR because entries not yet
    // visited still hold pre-reset contents.
    always_comb begin
        w_rvalid = '0;
        w_rbyp   = '0;
        w_rdata  = '0;
        for (int i = 0; i < NRD; i++) begin
            w_rvalid[i] = w_run && idx_ok(w_rsel[i]);
            w_rbyp[i]   = BYPASS && w_wr_ok && (bus.wsel == w_rsel[i]);
            if (!w_rvalid[i]) begin
                w_rdata[i] = '0;
            end else if (w_rbyp[i]) begin
                w_rdata[i] = bus.wdata;
            end else begin
                w_rdata[i] = r_mem[w_rsel[i]];
            end
        end
    end

    assign bus.rdata = w_rdata;

    // ---------------------------------------------------------------- busy
    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (c_AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set_en  (w_set_ok),
        .i_set_idx (bus.issue_rd),
        .i_clr_en  (w_wr_ok),
        .i_clr_idx (bus.wsel),
        .i_rsel    (w_rsel),
        .i_rvalid  (w_rvalid),
        .i_rbyp    (w_rbyp),
        .o_rbusy   (bus.rbusy)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Scoreboard bench for regfile_sb. Three instances:
//                  A : defaults (32 regs, 2 ports, zero reg, bypass)
//                  B : as A but without bypass
//                  C : 20 regs, 3 ports
//                Stimulus queues expected values tagged with the cycle they
//                apply to; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifb ();
    regfile_sb_if #(.XLEN(32), .NREGS(20), .NRD(3)) ifc ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    regfile_sb #(.XLEN(32), .NREGS(20), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    localparam int K_RDATA = 0;
    localparam int K_RBUSY = 1;
    localparam int K_READY = 2;

    typedef struct {
        int          tag;
        int          dut;
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_val(input int d, input int k, input int p,
                           input logic [31:0] v, input string nm);
        exp_t e;
        e.tag = cyc; e.dut = d; e.kind = k; e.port = p; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int d, input int k, input int p);
        logic [31:0] r;
        r = 32'hx;
        case (d)
            0: case (k)
                   K_RDATA: r = ifa.rdata[p*32 +: 32];
                   K_RBUSY: r = {31'b0, ifa.rbusy[p]};
                   default: r = {31'b0, ifa.ready};
               endcase
            1: case (k)
                   K_RDATA: r = ifb.rdata[p*32 +: 32];
                   K_RBUSY: r = {31'b0, ifb.rbusy[p]};
                   default: r = {31'b0, ifb.ready};
               endcase
            default: case (k)
                   K_RDATA: r = ifc.rdata[p*32 +: 32];
                   K_RBUSY: r = {31'b0, ifc.rbusy[p]};
                   default: r = {31'b0, ifc.ready};
               endcase
        endcase
        return r;
    endfunction

    // Monitor: compare every queued expectation in the cycle it was issued.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            a = actual(e.dut, e.kind, e.port);
            total++;
            if (a !== e.val || e.tag != cyc) begin
                bad++;
                $display("FAIL %s: dut=%0d port=%0d got=%h want=%h (cycle %0d, tag %0d)",
                         e.name, e.dut, e.port, a, e.val, cyc, e.tag);
            end
        end
    end

    task automatic idle(input int d);
        case (d)
            0: begin ifa.wen = 0; ifa.wsel = 0; ifa.wdata = 0; ifa.issue_en = 0; ifa.issue_rd = 0; end
            1: begin ifb.wen = 0; ifb.wsel = 0; ifb.wdata = 0; ifb.issue_en = 0; ifb.issue_rd = 0; end
            default: begin ifc.wen = 0; ifc.wsel = 0; ifc.wdata = 0; ifc.issue_en = 0; ifc.issue_rd = 0; end
        endcase
    endtask

    // Walk a full clear sequence: A/B need 32 edges, C needs 20.
    task automatic clear_check(input bit chk_rd);
        for (int i = 0; i < 32; i++) begin
            exp_val(0, K_READY, 0, 32'd0, "clr_ready_a");
            exp_val(1, K_READY, 0, 32'd0, "clr_ready_b");
            exp_val(2, K_READY, 0, (i >= 20) ? 32'd1 : 32'd0, "clr_ready_c");
            if (chk_rd) begin
                exp_val(0, K_RDATA, 0, 32'd0, "clr_rdata_a");
                exp_val(0, K_RBUSY, 0, 32'd0, "clr_rbusy_a");
                if (i < 20) exp_val(2, K_RDATA, 1, 32'd0, "clr_rdata_c");
            end
            tick();
        end
        exp_val(0, K_READY, 0, 32'd1, "ready_a");
        exp_val(1, K_READY, 0, 32'd1, "ready_b");
        exp_val(2, K_READY, 0, 32'd1, "ready_c");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(0); idle(1); idle(2);
        ifa.rsel = '0; ifb.rsel = '0; ifc.rsel = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_check(1'b0);

        // ---- reset/clear of a written register
        ifa.wen = 1; ifa.wsel = 3; ifa.wdata = 32'h1234_5678; ifa.rsel[4:0] = 5'd3;
        exp_val(0, K_RDATA, 0, 32'h1234_5678, "t1_byp");
        tick();
        idle(0);
        exp_val(0, K_RDATA, 0, 32'h1234_5678, "t1_hold");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // writes and issues during CLEAR must be ignored
        ifa.wen = 1; ifa.wsel = 5; ifa.wdata = 32'h55; ifa.issue_en = 1; ifa.issue_rd = 5;
        ifa.rsel[9:5] = 5'd5;
        ifc.rsel[9:5] = 5'd19;
        clear_check(1'b1);
        idle(0);
        exp_val(0, K_RDATA, 0, 32'd0, "t1_cleared");
        exp_val(0, K_RDATA, 1, 32'd0, "t1_clr_wen_ignored");
        exp_val(0, K_RBUSY, 1, 32'd0, "t1_clr_issue_ignored");
        tick();

        // ---- write/read with and without bypass
        ifa.wen = 1; ifa.wsel = 1; ifa.wdata = 32'hDEAD_BEEF; ifa.rsel[4:0] = 5'd1;
        ifb.wen = 1; ifb.wsel = 1; ifb.wdata = 32'hDEAD_BEEF; ifb.rsel[4:0] = 5'd1;
        exp_val(0, K_RDATA, 0, 32'hDEAD_BEEF, "t2_byp");
        exp_val(1, K_RDATA, 0, 32'd0, "t2_nobyp_old");
        tick();
        idle(0); idle(1);
        exp_val(0, K_RDATA, 0, 32'hDEAD_BEEF, "t2_a_next");
        exp_val(1, K_RDATA, 0, 32'hDEAD_BEEF, "t2_b_next");
        tick();

        // ---- zero register
        ifa.wen = 1; ifa.wsel = 0; ifa.wdata = 32'hFFFF_FFFF;
        ifa.issue_en = 1; ifa.issue_rd = 0; ifa.rsel = '0;
        exp_val(0, K_RDATA, 0, 32'd0, "t3_zero_byp");
        exp_val(0, K_RBUSY, 0, 32'd0, "t3_zero_busy_now");
        tick();
        idle(0);
        exp_val(0, K_RDATA, 0, 32'd0, "t3_zero_rd0");
        exp_val(0, K_RDATA, 1, 32'd0, "t3_zero_rd1");
        exp_val(0, K_RBUSY, 0, 32'd0, "t3_zero_busy0");
        exp_val(0, K_RBUSY, 1, 32'd0, "t3_zero_busy1");
        tick();

        // ---- scoreboard: issue x5 at n, write at n+3
        ifa.issue_en = 1; ifa.issue_rd = 5; ifa.rsel[4:0] = 5'd5;
        ifb.issue_en = 1; ifb.issue_rd = 5; ifb.rsel[4:0] = 5'd5;
        exp_val(0, K_RBUSY, 0, 32'd0, "t4_a_n");
        exp_val(1, K_RBUSY, 0, 32'd0, "t4_b_n");
        tick();
        idle(0); idle(1);
        exp_val(0, K_RBUSY, 0, 32'd1, "t4_a_n1");
        exp_val(1, K_RBUSY, 0, 32'd1, "t4_b_n1");
        tick();
        exp_val(0, K_RBUSY, 0, 32'd1, "t4_a_n2");
        tick();
        ifa.wen = 1; ifa.wsel = 5; ifa.wdata = 32'h0BAD_F00D;
        ifb.wen = 1; ifb.wsel = 5; ifb.wdata = 32'h0BAD_F00D;
        exp_val(0, K_RBUSY, 0, 32'd0, "t4_a_n3_busy");
        exp_val(0, K_RDATA, 0, 32'h0BAD_F00D, "t4_a_n3_data");
        exp_val(1, K_RBUSY, 0, 32'd1, "t4_b_n3_busy");
        exp_val(1, K_RDATA, 0, 32'd0, "t4_b_n3_data");
        tick();
        idle(0); idle(1);
        exp_val(0, K_RBUSY, 0, 32'd0, "t4_a_n4_busy");
        exp_val(0, K_RDATA, 0, 32'h0BAD_F00D, "t4_a_n4_data");
        exp_val(1, K_RBUSY, 0, 32'd0, "t4_b_n4_busy");
        exp_val(1, K_RDATA, 0, 32'h0BAD_F00D, "t4_b_n4_data");
        tick();

        // ---- simultaneous set and clear on x7
        ifa.issue_en = 1; ifa.issue_rd = 7; ifa.rsel[4:0] = 5'd7; ifa.rsel[9:5] = 5'd7;
        tick();
        idle(0);
        exp_val(0, K_RBUSY, 0, 32'd1, "t5_busy_before");
        tick();
        ifa.issue_en = 1; ifa.issue_rd = 7;
        ifa.wen = 1; ifa.wsel = 7; ifa.wdata = 32'h7777_8888;
        exp_val(0, K_RBUSY, 0, 32'd0, "t5_same_cycle_masked");
        exp_val(0, K_RDATA, 0, 32'h7777_8888, "t5_same_cycle_data");
        tick();
        idle(0);
        exp_val(0, K_RBUSY, 0, 32'd1, "t5_set_wins_p0");
        exp_val(0, K_RBUSY, 1, 32'd1, "t5_set_wins_p1");
        exp_val(0, K_RDATA, 0, 32'h7777_8888, "t5_written");
        tick();

        // ---- 20-register, 3-port variant: out-of-range index
        ifc.rsel[4:0] = 5'd25; ifc.rsel[9:5] = 5'd19; ifc.rsel[14:10] = 5'd19;
        ifc.wen = 1; ifc.wsel = 25; ifc.wdata = 32'hCAFE_F00D;
        ifc.issue_en = 1; ifc.issue_rd = 25;
        exp_val(2, K_RDATA, 0, 32'd0, "t6_oob_rd");
        exp_val(2, K_RDATA, 1, 32'd0, "t6_x19_old");
        tick();
        ifc.issue_en = 0;
        ifc.wen = 1; ifc.wsel = 19; ifc.wdata = 32'h1313_1313;
        exp_val(2, K_RBUSY, 0, 32'd0, "t6_oob_busy");
        exp_val(2, K_RDATA, 0, 32'd0, "t6_oob_rd_after");
        exp_val(2, K_RDATA, 1, 32'h1313_1313, "t6_x19_byp");
        tick();
        idle(2);
        exp_val(2, K_RDATA, 2, 32'h1313_1313, "t6_x19_p2");
        exp_val(2, K_RDATA, 0, 32'd0, "t6_oob_rd_final");
        exp_val(2, K_RBUSY, 0, 32'd0, "t6_oob_busy_final");
        tick();

        // ---- reset at clear step 10 restarts the sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_check(1'b1);
        exp_val(2, K_RDATA, 1, 32'd0, "t6_x19_recleared");
        exp_val(0, K_RDATA, 0, 32'd0, "t6_x7_recleared");
        exp_val(0, K_RBUSY, 0, 32'd0, "t6_busy_reset");
        tick();
        tick();

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending_expectations: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's integer register file. It provides configurable data width, register count and number of read ports, plus an optional hard-wired zero register and optional write-to-read bypass. It adds a per-register busy scoreboard and a post-reset clear sequencer, so the array carries no reset logic and is FPGA-RAM friendly. It sits between decode/issue (read, mark-busy) and writeback (write, clear-busy) in the core.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; need not be a power of 2; AW = $clog2(NREGS)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
ready  out  1  high when the clear sequence is done and the block accepts operations
wen  in  1  writeback enable
wsel  in  AW  writeback register index
wdata  in  XLEN  writeback data
rsel  in  NRD*AW  read indices; port i uses bits [i*AW +: AW]
rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rbusy  out  NRD  port i's register has an outstanding producer
issue_en  in  1  mark register issue_rd busy
issue_rd  in  AW  destination register of the issued instruction

Behaviour:
- FSM states are CLEAR and RUN. The sequencer holds clr_idx (AW bits).
- rst=1 at an edge: next state is CLEAR, clr_idx=0, all busy bits 0, ready=0. This applies in any state, including mid-CLEAR, which restarts at index 0.
- CLEAR with rst=0: each edge writes 0 to entry clr_idx and increments clr_idx.
  - The edge that writes entry NREGS-1 moves the FSM to RUN.
  - ready rises exactly NREGS edges after the first edge with rst=0.
- Reset value of outputs: ready=0; rbusy=0; rdata=0 throughout CLEAR, forced regardless of array contents.
- In CLEAR, wen and issue_en are ignored.
- No initial-block dependence: correctness relies only on the clear sequence.
- Write (RUN): at a posedge with wen=1, the entry wsel takes wdata. The write is dropped if ZERO_REG and wsel==0, or if wsel >= NREGS.
- Read (RUN): combinational, zero-latency.
  - rdata[i] = 0 if rsel[i] >= NREGS, or if ZERO_REG and rsel[i]==0.
  - Otherwise, if BYPASS and wen and wsel==rsel[i], rdata[i] = wdata.
  - Otherwise rdata[i] is the array contents.
  - Without BYPASS, a same-cycle read returns the old value; the new value is visible from the next cycle.
- Scoreboard (RUN), busy[NREGS]:
  - issue_en sets busy[issue_rd].
  - A valid write (wen, in range, not the zero register) clears busy[wsel].
  - Same edge, same register for both: set wins, because a newer producer is in flight.
  - issue to register 0 with ZERO_REG, or issue_rd >= NREGS: ignored.
- rbusy[i] = busy[rsel[i]] AND NOT (BYPASS AND wen AND wsel==rsel[i]). The forwarded value resolves the hazard in the same cycle. rsel out of range or the zero register gives 0.
- rbusy reflects registered busy state only; an issue in cycle n shows on rbusy from cycle n+1.
- All read ports are independent; duplicate rsel values on different ports are legal.

Decomposition:
- Package regfile_pkg holds:
  - the state enum rf_state_e {CLEAR, RUN};
  - default constants RF_XLEN=32, RF_NREGS=32, RF_NRD=2;
  - the function rf_aw(n) returning $clog2(n).
- One natural sub-module, regfile_scoreboard. It owns the busy vector, the set/clear priority and the rbusy generation, with bypass masking passed in.
- Top level holds the array, the clear FSM, read muxing and bypass.

Test Plan:
1. Reset/clear: write x3=0x12345678, assert rst for 1 cycle, then deassert -> ready=0 for exactly 32 edges, rdata=0 during CLEAR, then ready=1 and rsel0=3 reads 0x00000000.
2. Write/read: RUN, wen, wsel=1, wdata=0xDEADBEEF, rsel0=1 -> same cycle rdata0=0xDEADBEEF via bypass; with BYPASS=0 it shows the old 0 and reads 0xDEADBEEF next cycle.
3. Zero register: wen, wsel=0, wdata=0xFFFFFFFF; issue_en with issue_rd=0 -> rdata for rsel=0 is 0, rbusy=0 on all ports.
4. Scoreboard: issue x5 at cycle n -> rbusy0=1 (rsel0=5) from n+1; wen x5 at n+3 -> rbusy0=0 and rdata0=wdata at n+3; busy stays 0 at n+4.
5. Simultaneous set/clear: x7 busy; same cycle issue_rd=7 and wen wsel=7 -> after the edge rbusy for 7 = 1 and the register holds wdata.
6. Reset mid-CLEAR: rst at clear step 10 -> clr_idx restarts at 0, ready rises NREGS edges after rst drops; NREGS=20, NRD=3 variant: wsel=25 write dropped, rsel=25 reads 0.
